// File: rtl/lfsr_engine.sv
// Parametrised LFSR with runtime Fibonacci/Galois selection, latched seed,
// registered wrap detection, seed-to-seed period measurement and lock-up flag.
module lfsr_engine #(
  parameter int unsigned     N    = 8,
  parameter logic [N-1:0]    POLY = 8'h71
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_seed,
  input  logic [N-1:0] seed_data,
  input  logic         enable,
  input  logic         mode,
  output logic [N-1:0] lfsr_data,
  output logic         lfsr_done,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         lfsr_lockup
);

  logic [N-1:0] seed_q;
  logic [N-1:0] count;
  logic         mode_q;
  logic         fib_fb;
  logic [N-1:0] fib_next;
  logic [N-1:0] gal_next;
  logic [N-1:0] next;
  logic         mode_chg;
  logic         wrap;

  always_comb begin
    fib_fb   = lfsr_data[N-1] ^ (^(lfsr_data[N-2:0] & POLY[N-1:1]));
    fib_next = {lfsr_data[N-2:0], fib_fb};
    gal_next = {lfsr_data[N-2:0], 1'b0} ^ (lfsr_data[N-1] ? POLY : '0);
    next     = mode ? gal_next : fib_next;
    mode_chg = (mode != mode_q);
    wrap     = (next == seed_q);
  end

  assign lfsr_lockup = (lfsr_data == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_data    <= '0;
      seed_q       <= '0;
      count        <= '0;
      lfsr_done    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      mode_q    <= mode;
      lfsr_done <= 1'b0;
      if (load_seed) begin
        lfsr_data    <= seed_data;
        seed_q       <= seed_data;
        count        <= '0;
        period_valid <= 1'b0;
      end else if (enable && !lfsr_lockup) begin
        lfsr_data <= next;
        // A mode switch restarts the measurement; the switching step counts as one.
        if (mode_chg) begin
          count        <= N'(1);
          period_valid <= 1'b0;
        end else if (wrap) begin
          lfsr_done    <= 1'b1;
          period       <= count + 1'b1;
          period_valid <= 1'b1;
          count        <= '0;
        end else if (count != '1) begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule
